// File: rtl/ula_pkg.sv
// Shared definitions for the ALU sequencer: FSM states, instruction types
// and the eight ALU operation codes seen by the downstream ALU.
package ula_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    EXECUTA = 2'd2,
    ESCRITA = 2'd3
  } estado_t;

  localparam logic TIPO_ULA = 1'b0;
  localparam logic TIPO_IMM = 1'b1;

  localparam logic [2:0] SEL_AND   = 3'b000;
  localparam logic [2:0] SEL_OR    = 3'b001;
  localparam logic [2:0] SEL_NOT   = 3'b010;
  localparam logic [2:0] SEL_SUB   = 3'b011;
  localparam logic [2:0] SEL_ADD   = 3'b100;
  localparam logic [2:0] SEL_XOR   = 3'b101;
  localparam logic [2:0] SEL_PASSA = 3'b110;
  localparam logic [2:0] SEL_PASSB = 3'b111;

endpackage

// File: rtl/ula_sequenciador_banco_reg.sv
// Four-entry register bank: two asynchronous read ports, one synchronous
// write port, cleared by the asynchronous reset.
module banco_reg #(
  parameter int LARGURA = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en_i,
  input  logic [1:0]         wr_addr_i,
  input  logic [LARGURA-1:0] wr_data_i,
  input  logic [1:0]         rd_addr_a_i,
  input  logic [1:0]         rd_addr_b_i,
  output logic [LARGURA-1:0] rd_data_a_o,
  output logic [LARGURA-1:0] rd_data_b_o
);

  logic [LARGURA-1:0] bank_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) bank_q[i] <= '0;
    end else if (wr_en_i) begin
      bank_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = bank_q[rd_addr_a_i];
  assign rd_data_b_o = bank_q[rd_addr_b_i];

endmodule

// File: rtl/ula_sequenciador.sv
// Four-state instruction sequencer: fetches operands from the register bank,
// drives an external ALU, and writes the result back with a one-cycle done pulse.
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int LARGURA = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_valid,
  output logic               inst_ready,
  input  logic               inst_tipo,
  input  logic [2:0]         inst_sel,
  input  logic [1:0]         inst_rd,
  input  logic [1:0]         inst_ra,
  input  logic [1:0]         inst_rb,
  input  logic [LARGURA-1:0] inst_imm,
  output logic [LARGURA-1:0] ula_A,
  output logic [LARGURA-1:0] ula_B,
  output logic               ula_Cin,
  output logic [2:0]         ula_seletor,
  input  logic [LARGURA-1:0] ula_resultado,
  input  logic               ula_Cout,
  output logic               done,
  output logic [LARGURA-1:0] done_dado,
  output logic               flag_carry,
  output logic               flag_zero
);

  estado_t            estado_q;
  logic               tipo_q;
  logic [2:0]         sel_q;
  logic [1:0]         rd_q, ra_q, rb_q;
  logic [LARGURA-1:0] imm_q;
  logic [LARGURA-1:0] op_a_q, op_b_q, result_q;
  logic               carry_q, zero_q, done_q, ready_q;
  logic [LARGURA-1:0] bank_a, bank_b;

  banco_reg #(.LARGURA(LARGURA)) u_banco (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (estado_q == ESCRITA),
    .wr_addr_i   (rd_q),
    .wr_data_i   (result_q),
    .rd_addr_a_i (ra_q),
    .rd_addr_b_i (rb_q),
    .rd_data_a_o (bank_a),
    .rd_data_b_o (bank_b)
  );

  // Ready is registered so it is high in the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      tipo_q   <= 1'b0;
      sel_q    <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      imm_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (inst_valid && ready_q) begin
            tipo_q   <= inst_tipo;
            sel_q    <= inst_sel;
            rd_q     <= inst_rd;
            ra_q     <= inst_ra;
            rb_q     <= inst_rb;
            imm_q    <= inst_imm;
            ready_q  <= 1'b0;
            estado_q <= BUSCA;
          end
        end
        BUSCA: begin
          op_a_q   <= bank_a;
          op_b_q   <= bank_b;
          estado_q <= EXECUTA;
        end
        EXECUTA: begin
          result_q <= (tipo_q == TIPO_IMM) ? imm_q : ula_resultado;
          if (tipo_q == TIPO_ULA && sel_q == SEL_ADD) carry_q <= ula_Cout;
          done_q   <= 1'b1;
          estado_q <= ESCRITA;
        end
        ESCRITA: begin
          zero_q   <= (result_q == '0);
          done_q   <= 1'b0;
          ready_q  <= 1'b1;
          estado_q <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign inst_ready  = ready_q;
  assign ula_A       = op_a_q;
  assign ula_B       = op_b_q;
  assign ula_Cin     = carry_q;
  assign ula_seletor = sel_q;
  assign done        = done_q;
  assign done_dado   = result_q;
  assign flag_carry  = carry_q;
  assign flag_zero   = zero_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Scoreboard bench for ula_sequenciador: directed instructions push hand-computed
// results, an independent monitor checks each done pulse and the flags after it.
module tb_ula_sequenciador;
  import ula_pkg::*;

  typedef struct {
    logic       tipo;
    logic [2:0] sel;
    logic [1:0] rd, ra, rb;
    logic [3:0] imm;
    logic [3:0] dado;
    logic       carry;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [3:0] dado;
    logic       carry;
    logic       zero;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inst_valid = 1'b0;
  logic       inst_ready;
  logic       inst_tipo = 1'b0;
  logic [2:0] inst_sel = '0;
  logic [1:0] inst_rd = '0, inst_ra = '0, inst_rb = '0;
  logic [3:0] inst_imm = '0;
  logic [3:0] ula_A, ula_B, ula_resultado;
  logic       ula_Cin, ula_Cout;
  logic [2:0] ula_seletor;
  logic       done, flag_carry, flag_zero;
  logic [3:0] done_dado;

  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  exp_t expQ [$];

  ula_sequenciador #(.LARGURA(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_tipo     (inst_tipo),
    .inst_sel      (inst_sel),
    .inst_rd       (inst_rd),
    .inst_ra       (inst_ra),
    .inst_rb       (inst_rb),
    .inst_imm      (inst_imm),
    .ula_A         (ula_A),
    .ula_B         (ula_B),
    .ula_Cin       (ula_Cin),
    .ula_seletor   (ula_seletor),
    .ula_resultado (ula_resultado),
    .ula_Cout      (ula_Cout),
    .done          (done),
    .done_dado     (done_dado),
    .flag_carry    (flag_carry),
    .flag_zero     (flag_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ALU: carry-out is only meaningful for add/sub, zero otherwise.
  always_comb begin
    ula_resultado = '0;
    ula_Cout = 1'b0;
    case (ula_seletor)
      SEL_AND:   ula_resultado = ula_A & ula_B;
      SEL_OR:    ula_resultado = ula_A | ula_B;
      SEL_NOT:   ula_resultado = ~ula_A;
      SEL_SUB:   {ula_Cout, ula_resultado} = {1'b0, ula_A} - {1'b0, ula_B};
      SEL_ADD:   {ula_Cout, ula_resultado} = {1'b0, ula_A} + {1'b0, ula_B} + {4'b0, ula_Cin};
      SEL_XOR:   ula_resultado = ula_A ^ ula_B;
      SEL_PASSA: ula_resultado = ula_A;
      default:   ula_resultado = ula_B;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic vec_t mk(input logic tipo, input logic [2:0] sel, input logic [1:0] rd,
                              input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] imm,
                              input logic [3:0] dado, input logic carry, input logic zero);
    vec_t v;
    v.tipo = tipo; v.sel = sel; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
    v.dado = dado; v.carry = carry; v.zero = zero;
    return v;
  endfunction

  task automatic driveFields(input vec_t v);
    inst_tipo = v.tipo; inst_sel = v.sel; inst_rd = v.rd;
    inst_ra = v.ra; inst_rb = v.rb; inst_imm = v.imm;
  endtask

  task automatic pushExp(input vec_t v, input int acceptCyc);
    exp_t e;
    e.dado = v.dado; e.carry = v.carry; e.zero = v.zero; e.cyc = acceptCyc + 3;
    expQ.push_back(e);
  endtask

  // Returns on a negedge where inst_ready is high, or flags a timeout.
  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkCount++;
      $display("[TB] FAIL ready_timeout: inst_ready stayed 0, expected 1");
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit expectDone);
    bit ok;
    waitReady(ok);
    if (ok) begin
      driveFields(v);
      inst_valid = 1'b1;
      if (expectDone) pushExp(v, cyc);
      @(negedge clk);
      inst_valid = 1'b0;
      driveFields(mk(1'b1, 3'b111, 2'd3, 2'd3, 2'd3, 4'hF, 4'h0, 1'b0, 1'b0));
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_done: done=1 with dado %0h, expected no done", done_dado);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_dado", done_dado, e.dado);
          checkOutput("flag_carry", flag_carry, e.carry);
          checkOutput("done_latency", cyc, e.cyc);
          @(negedge clk);
          checkOutput("done_one_cycle", done, 0);
          checkOutput("flag_zero", flag_zero, e.zero);
          checkOutput("ready_after_done", inst_ready, 1);
        end
      end
    end
  end

  initial begin
    vec_t seq [$];
    vec_t burst [8];
    bit ok;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", inst_ready, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_done_dado", done_dado, 0);
    checkOutput("rst_carry", flag_carry, 0);
    checkOutput("rst_zero", flag_zero, 0);
    checkOutput("rst_ula_A", ula_A, 0);
    checkOutput("rst_ula_B", ula_B, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_release", inst_ready, 1);

    //                tipo      sel        rd    ra    rb    imm   dado  c     z
    seq.push_back(mk(TIPO_IMM, SEL_AND,   2'd1, 2'd0, 2'd0, 4'h9, 4'h9, 1'b0, 1'b0));
    seq.push_back(mk(TIPO_IMM, SEL_AND,   2'd2, 2'd0, 2'd0, 4'h8, 4'h8, 1'b0, 1'b0));
    seq.push_back(mk(TIPO_ULA, SEL_ADD,   2'd3, 2'd1, 2'd2, 4'h0, 4'h1, 1'b1, 1'b0));
    seq.push_back(mk(TIPO_ULA, SEL_ADD,   2'd0, 2'd0, 2'd0, 4'h0, 4'h1, 1'b0, 1'b0));
    seq.push_back(mk(TIPO_IMM, SEL_AND,   2'd1, 2'd0, 2'd0, 4'hA, 4'hA, 1'b0, 1'b0));
    seq.push_back(mk(TIPO_IMM, SEL_AND,   2'd2, 2'd0, 2'd0, 4'hA, 4'hA, 1'b0, 1'b0));
    seq.push_back(mk(TIPO_ULA, SEL_ADD,   2'd3, 2'd1, 2'd2, 4'h0, 4'h4, 1'b1, 1'b0));
    seq.push_back(mk(TIPO_ULA, SEL_AND,   2'd1, 2'd1, 2'd2, 4'h0, 4'hA, 1'b1, 1'b0));
    seq.push_back(mk(TIPO_ULA, SEL_XOR,   2'd2, 2'd1, 2'd2, 4'h0, 4'h0, 1'b1, 1'b1));
    foreach (seq[i]) applyStimulus(seq[i], 1'b1);

    // Valid held high with fields changing every cycle; only slots 0 and 4 land.
    burst[0] = mk(TIPO_IMM, SEL_AND,   2'd3, 2'd0, 2'd0, 4'h5, 4'h5, 1'b1, 1'b0);
    burst[1] = mk(TIPO_IMM, SEL_AND,   2'd3, 2'd0, 2'd0, 4'h7, 4'h7, 1'b1, 1'b0);
    burst[2] = mk(TIPO_ULA, SEL_ADD,   2'd0, 2'd0, 2'd0, 4'h0, 4'h3, 1'b0, 1'b0);
    burst[3] = mk(TIPO_IMM, SEL_AND,   2'd0, 2'd0, 2'd0, 4'hF, 4'hF, 1'b1, 1'b0);
    burst[4] = mk(TIPO_ULA, SEL_PASSA, 2'd0, 2'd3, 2'd1, 4'h0, 4'h5, 1'b1, 1'b0);
    burst[5] = mk(TIPO_IMM, SEL_AND,   2'd3, 2'd0, 2'd0, 4'hE, 4'hE, 1'b1, 1'b0);
    burst[6] = mk(TIPO_ULA, SEL_XOR,   2'd3, 2'd3, 2'd3, 4'h0, 4'h0, 1'b1, 1'b1);
    burst[7] = mk(TIPO_ULA, SEL_ADD,   2'd1, 2'd0, 2'd3, 4'h0, 4'hA, 1'b0, 1'b0);
    waitReady(ok);
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        if (i > 0) @(negedge clk);
        driveFields(burst[i]);
        inst_valid = 1'b1;
        checkOutput($sformatf("burst_ready_%0d", i), inst_ready, (i % 4 == 0));
        if (inst_ready) pushExp(burst[i], cyc);
      end
      @(negedge clk);
      inst_valid = 1'b0;
    end

    // Reset during EXECUTA of a load into r2: no write-back, no done.
    applyStimulus(mk(TIPO_IMM, SEL_AND, 2'd2, 2'd0, 2'd0, 4'h3, 4'h3, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", inst_ready, 1);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_carry", flag_carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready_release", inst_ready, 1);
    applyStimulus(mk(TIPO_ULA, SEL_PASSA, 2'd1, 2'd2, 2'd0, 4'h0, 4'h0, 1'b0, 1'b1), 1'b1);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ula_sequenciador.md
ULA_SEQUENCIADOR -- requirements
Module: ula_sequenciador

Interface
REQ-001 SHALL have parameter LARGURA, default 4, data width of registers and ALU operands.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports inst_valid  input  1 and inst_ready  output  1, the instruction handshake.
REQ-005 SHALL have port inst_tipo  input  1  0 = ALU operation, 1 = load immediate.
REQ-006 SHALL have port inst_sel  input  3  ALU operation code, passed to ula_seletor.
REQ-007 SHALL have ports inst_rd, inst_ra, inst_rb  input  2 each  destination and source register indices.
REQ-008 SHALL have port inst_imm  input  LARGURA  immediate value for loads.
REQ-009 SHALL have ports ula_A, ula_B  output  LARGURA each, ula_Cin  output  1, ula_seletor  output  3, all feeding the downstream ALU.
REQ-010 SHALL have ports ula_resultado  input  LARGURA and ula_Cout  input  1, both returned combinationally by the ALU.
REQ-011 SHALL have ports done  output  1, done_dado  output  LARGURA, flag_carry  output  1, flag_zero  output  1.

Function
REQ-012 SHALL contain a 4 x LARGURA register bank, indexed by 2-bit addresses.
REQ-013 SHALL implement FSM states OCIOSO, BUSCA, EXECUTA, ESCRITA; transitions OCIOSO->BUSCA on handshake, BUSCA->EXECUTA, EXECUTA->ESCRITA, ESCRITA->OCIOSO unconditionally.
REQ-014 SHALL assert inst_ready only in OCIOSO; instruction accepted at edge E where inst_valid and inst_ready are both 1; all inst_* fields latched at E.
REQ-015 SHALL, at edge E+1 (BUSCA), load operand registers with bank[ra] and bank[rb]; ula_A and ula_B driven directly from these registers.
REQ-016 SHALL drive ula_seletor from latched inst_sel and ula_Cin from flag_carry at all times.
REQ-017 SHALL, at edge E+2 (EXECUTA), capture the result register: ula_resultado for tipo 0, latched imm for tipo 1.
REQ-018 SHALL update flag_carry at E+2 with ula_Cout only when tipo 0 and sel = 3'b100; otherwise flag_carry unchanged.
REQ-019 SHALL assert done for exactly one cycle, during ESCRITA (cycle after E+2), with done_dado = result register.
REQ-020 SHALL, at edge E+3, write result to bank[rd], set flag_zero = (result == 0), return to OCIOSO.
REQ-021 SHALL give fixed latency: done 3 cycles after acceptance; maximum throughput one instruction per 4 cycles.
REQ-022 SHALL handle ra == rb, and rd == ra or rb: operands read at E+1 use pre-write values; no hazard since next instruction is accepted no earlier than E+4.
REQ-023 SHALL ignore inst_valid and all inst_* changes outside OCIOSO.

Reset
REQ-024 SHALL, on rst_n low, immediately set state OCIOSO, bank entries, operand, result and latched instruction registers to 0, flags to 0, done to 0.
REQ-025 SHALL abort any in-flight instruction on reset mid-operation with no bank write and no done pulse.
REQ-026 SHALL assert inst_ready in the first cycle after rst_n deasserts.

Structure
REQ-027 SHALL take state encoding, inst_tipo constants and the eight ALU operation codes from shared package ula_pkg.
REQ-028 SHALL place the register bank in sub-module banco_reg (two async read ports, one sync write port, async reset).

Verification
REQ-029 SHALL check: load imm 4'h9 to r1 -> done at E+3, done_dado=9, flag_zero=0, ready high one cycle later.
REQ-030 SHALL check: r1=9, r2=8, add (sel 100) rd=r3, flag_carry=0 -> done_dado=4'h1, flag_carry=1; then add r0+r0 (both 0) -> done_dado=4'h1 (Cin used), flag_carry=0.
REQ-031 SHALL check: r1=4'hA, r2=4'hA, sel 000 rd=r1 then sel 101 rd=r2 with ra=r1, rb=r2 -> results 4'hA then 4'h0, flag_zero=1, flag_carry unchanged.
REQ-032 SHALL check: inst_valid held high continuously with changing fields -> only the instruction present at each acceptance edge executes, one every 4 cycles.
REQ-033 SHALL check: rst_n pulsed low during EXECUTA of a write to r2 -> r2 reads 0, no done, inst_ready high after release.
